// File: rtl/disk2_softswitch.sv
// Disk II I/O-page bus slave: soft switches, motor-off delay, read latch/status
// return and write-byte capture, all timed from phi_2 edges seen on fpga_clk.
module disk2_softswitch #(
  parameter int MOTOR_OFF_CYCLES = 1023000,
  parameter int CNT_W            = 20
) (
  input  logic       fpga_clk,
  input  logic       reset,
  input  logic       phi_0,
  input  logic       phi_2,
  input  logic       dev_sel_n,
  input  logic [3:0] addr,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] rd_byte,
  input  logic       rd_byte_vld,
  input  logic       write_prot,
  output logic [3:0] phase,
  output logic       motor_on,
  output logic       drive_sel,
  output logic       q6,
  output logic       q7,
  output logic [7:0] wr_byte,
  output logic       wr_load
);

  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(MOTOR_OFF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             phi2_q;
  logic             rise;
  logic             fall;
  logic             access;
  logic [2:0]       sw;
  logic             sw_val;
  logic             q6_nxt;
  logic             q7_nxt;
  logic             rd_qual;
  logic             wr_qual;
  logic             latch_clr;
  logic [7:0]       latch;
  logic [7:0]       rd_mux;
  logic [CNT_W-1:0] motor_cnt;

  // Bus edges are taken from phi_2 alone; phi_0 carries no extra information here.
  logic unused_phi0;
  assign unused_phi0 = phi_0;

  assign rise    = phi_2 & ~phi2_q;
  assign fall    = ~phi_2 & phi2_q;
  assign access  = fall & ~dev_sel_n;
  assign sw      = addr[3:1];
  assign sw_val  = addr[0];
  assign rd_qual = ~dev_sel_n & rw & ~sw_val;

  assign q6_nxt = (access && sw == 3'd6) ? sw_val : q6;
  assign q7_nxt = (access && sw == 3'd7) ? sw_val : q7;

  // A write needs write mode and Q6 as they stand after this access's own switch update.
  assign wr_qual   = access & ~rw & sw_val & q7_nxt & q6_nxt;
  assign latch_clr = access & rw & ~sw_val & ~q7 & ~q6 & latch[7];

  always_comb begin
    rd_mux = latch;
    if ({q7, q6} == 2'b01) rd_mux = {write_prot, 7'b0};
  end

  always_ff @(posedge fpga_clk or negedge reset) begin
    if (!reset) phi2_q <= 1'b0;
    else        phi2_q <= phi_2;
  end

  always_ff @(posedge fpga_clk or negedge reset) begin
    if (!reset) begin
      phase     <= 4'b0;
      drive_sel <= 1'b0;
      q6        <= 1'b0;
      q7        <= 1'b0;
    end else begin
      if (access && !addr[3]) phase[addr[2:1]] <= sw_val;
      if (access && sw == 3'd5) drive_sel <= sw_val;
      q6 <= q6_nxt;
      q7 <= q7_nxt;
    end
  end

  // Access outranks the off-delay countdown; an off-access while counting does not reload.
  always_ff @(posedge fpga_clk or negedge reset) begin
    if (!reset) begin
      motor_on  <= 1'b0;
      motor_cnt <= '0;
    end else if (access && sw == 3'd4 && sw_val) begin
      motor_on  <= 1'b1;
      motor_cnt <= '0;
    end else if (access && sw == 3'd4 && motor_on && motor_cnt == '0) begin
      motor_cnt <= OFF_LOAD;
    end else if (fall && motor_cnt != '0) begin
      motor_cnt <= motor_cnt - CNT_ONE;
      if (motor_cnt == CNT_ONE) motor_on <= 1'b0;
    end
  end

  always_ff @(posedge fpga_clk or negedge reset) begin
    if (!reset)           latch <= 8'h00;
    else if (rd_byte_vld) latch <= rd_byte;
    else if (latch_clr)   latch <= 8'h00;
  end

  always_ff @(posedge fpga_clk or negedge reset) begin
    if (!reset) begin
      data_oe  <= 1'b0;
      data_out <= 8'h00;
    end else if (fall) begin
      data_oe <= 1'b0;
    end else if (rise && rd_qual) begin
      data_oe  <= 1'b1;
      data_out <= rd_mux;
    end
  end

  always_ff @(posedge fpga_clk or negedge reset) begin
    if (!reset) begin
      wr_byte <= 8'h00;
      wr_load <= 1'b0;
    end else begin
      wr_load <= wr_qual;
      if (wr_qual) wr_byte <= data_in;
    end
  end

endmodule

// File: tb/tb_disk2_softswitch.sv
// Bench for disk2_softswitch: directed vector table, hand-written motor/latch/reset
// sequences, then random bus cycles against a bus-cycle-level reference model.
module tb_disk2_softswitch;

  localparam int MOFF = 10;

  logic       fpga_clk = 1'b0;
  logic       reset;
  logic       phi_0, phi_2, dev_sel_n, rw, rd_byte_vld, write_prot;
  logic [3:0] addr;
  logic [7:0] data_in, rd_byte;
  logic [7:0] data_out, wr_byte;
  logic       data_oe, motor_on, drive_sel, q6, q7, wr_load;
  logic [3:0] phase;

  disk2_softswitch #(.MOTOR_OFF_CYCLES(MOFF), .CNT_W(20)) dut (
    .fpga_clk(fpga_clk), .reset(reset), .phi_0(phi_0), .phi_2(phi_2),
    .dev_sel_n(dev_sel_n), .addr(addr), .rw(rw), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .rd_byte(rd_byte),
    .rd_byte_vld(rd_byte_vld), .write_prot(write_prot), .phase(phase),
    .motor_on(motor_on), .drive_sel(drive_sel), .q6(q6), .q7(q7),
    .wr_byte(wr_byte), .wr_load(wr_load)
  );

  always #5 fpga_clk = ~fpga_clk;

  int n_checks = 0;
  int n_errors = 0;

  // samples taken during one bus cycle
  logic       s_oe_hi, s_oe_hi2, s_oe_lo;
  logic [7:0] s_dout, s_dout2, s_wrb;
  int         s_wr;

  // reference model state
  logic [3:0] m_phase;
  logic       m_motor, m_pending, m_dsel, m_q6, m_q7;
  logic [7:0] m_latch, m_wrb;
  int         m_deadline, m_fall;
  logic       e_oe;
  logic [7:0] e_dout;
  int         e_wr;

  typedef struct {
    logic [3:0] a;
    logic       rw;
    logic [7:0] d;
    logic       sel_n;
    logic       wp;
    logic [3:0] e_phase;
    logic       e_motor;
    logic       e_dsel;
    logic       e_q6;
    logic       e_q7;
    logic       e_oe;
    logic [7:0] e_dout;
    int         e_wr;
    logic [7:0] e_wrb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge fpga_clk);
    rd_byte = b; rd_byte_vld = 1'b1;
    @(negedge fpga_clk);
    rd_byte_vld = 1'b0;
  endtask

  task automatic bus_cycle(input logic [3:0] a, input logic r, input logic [7:0] d,
                           input logic sel_n, input logic wp, input logic fs,
                           input logic [7:0] fb);
    @(negedge fpga_clk);
    addr = a; rw = r; data_in = d; dev_sel_n = sel_n; write_prot = wp;
    @(negedge fpga_clk);
    phi_2 = 1'b1; phi_0 = 1'b1;
    @(negedge fpga_clk);
    s_oe_hi = data_oe; s_dout = data_out;
    repeat (2) @(negedge fpga_clk);
    s_oe_hi2 = data_oe; s_dout2 = data_out;
    phi_2 = 1'b0; phi_0 = 1'b0;
    if (fs) begin rd_byte = fb; rd_byte_vld = 1'b1; end
    @(negedge fpga_clk);
    rd_byte_vld = 1'b0;
    s_oe_lo = data_oe; s_wr = int'(wr_load); s_wrb = wr_byte;
    @(negedge fpga_clk);
    s_wr += int'(wr_load);
    dev_sel_n = 1'b1; rw = 1'b1;
  endtask

  task automatic idle_cycle();
    bus_cycle(4'h0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic model_reset();
    m_phase = 4'b0; m_motor = 1'b0; m_pending = 1'b0; m_dsel = 1'b0;
    m_q6 = 1'b0; m_q7 = 1'b0; m_latch = 8'h00; m_wrb = 8'h00;
    m_deadline = 0; m_fall = 0;
  endtask

  // One full bus cycle at the level of the soft-switch rules; the motor keeps an
  // absolute deadline in falls rather than a countdown.
  task automatic model_cycle(input logic [3:0] a, input logic r, input logic [7:0] d,
                             input logic sel_n, input logic wp);
    logic acc, v;
    acc = !sel_n;
    v   = a[0];
    e_oe   = acc && r && !v;
    e_dout = (!m_q7 && m_q6) ? {wp, 7'b0} : m_latch;
    e_wr   = 0;
    m_fall++;
    if (e_oe && !m_q7 && !m_q6 && m_latch[7]) m_latch = 8'h00;
    if (acc) begin
      case (a[3:1])
        3'd0, 3'd1, 3'd2, 3'd3: m_phase[a[2:1]] = v;
        3'd4: begin
          if (v) begin
            m_motor = 1'b1; m_pending = 1'b0;
          end else if (m_motor && !m_pending) begin
            m_pending = 1'b1; m_deadline = m_fall + MOFF;
          end
        end
        3'd5: m_dsel = v;
        3'd6: m_q6 = v;
        default: m_q7 = v;
      endcase
    end
    if (m_pending && m_fall == m_deadline) begin
      m_motor = 1'b0; m_pending = 1'b0;
    end
    if (acc && !r && v && m_q7 && m_q6) begin
      e_wr = 1; m_wrb = d;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; phi_0 = 1'b0; phi_2 = 1'b0; dev_sel_n = 1'b1; rw = 1'b1;
    addr = 4'h0; data_in = 8'h00; rd_byte = 8'h00; rd_byte_vld = 1'b0; write_prot = 1'b0;

    //           a     rw    d      sel   wp    phase    mot   dsel  q6    q7    oe    dout   wr wrb
    vecs.push_back('{4'h1, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00});
    vecs.push_back('{4'h3, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00});
    vecs.push_back('{4'h0, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00});
    vecs.push_back('{4'hD, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 8'h00});
    vecs.push_back('{4'hE, 1'b1, 8'h00, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 0, 8'h00});
    vecs.push_back('{4'hF, 1'b0, 8'h96, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1, 8'h96});
    vecs.push_back('{4'hC, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 0, 8'h00});
    vecs.push_back('{4'hF, 1'b0, 8'h3C, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00});
    vecs.push_back('{4'hE, 1'b1, 8'h00, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00});
    vecs.push_back('{4'hB, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00});
    vecs.push_back('{4'hA, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00});
    vecs.push_back('{4'h5, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00});
    vecs.push_back('{4'h7, 1'b1, 8'h00, 1'b0, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00});
    vecs.push_back('{4'h6, 1'b1, 8'h00, 1'b1, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00});
    vecs.push_back('{4'h9, 1'b1, 8'h00, 1'b0, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00});
    vecs.push_back('{4'hD, 1'b0, 8'h11, 1'b0, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 8'h00});
    vecs.push_back('{4'hC, 1'b0, 8'h22, 1'b0, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00});

    repeat (3) @(negedge fpga_clk);
    reset = 1'b1;
    @(negedge fpga_clk);
    check("rst_phase", phase, 0);
    check("rst_motor", motor_on, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_data_out", data_out, 0);
    check("rst_wr_load", wr_load, 0);
    check("rst_wr_byte", wr_byte, 0);
    check("rst_switches", {drive_sel, q6, q7}, 0);

    foreach (vecs[i]) begin
      bus_cycle(vecs[i].a, vecs[i].rw, vecs[i].d, vecs[i].sel_n, vecs[i].wp, 1'b0, 8'h00);
      check($sformatf("vec%0d_phase", i), phase, vecs[i].e_phase);
      check($sformatf("vec%0d_motor", i), motor_on, vecs[i].e_motor);
      check($sformatf("vec%0d_dsel_q6_q7", i), {drive_sel, q6, q7},
            {vecs[i].e_dsel, vecs[i].e_q6, vecs[i].e_q7});
      check($sformatf("vec%0d_oe_hi", i), {s_oe_hi, s_oe_hi2}, {2{vecs[i].e_oe}});
      check($sformatf("vec%0d_oe_lo", i), s_oe_lo, 0);
      check($sformatf("vec%0d_wr_pulses", i), s_wr, vecs[i].e_wr);
      if (vecs[i].e_oe) begin
        check($sformatf("vec%0d_dout", i), s_dout, vecs[i].e_dout);
        check($sformatf("vec%0d_dout_stable", i), s_dout2, vecs[i].e_dout);
      end
      if (vecs[i].e_wr != 0) check($sformatf("vec%0d_wr_byte", i), s_wrb, vecs[i].e_wrb);
    end

    // motor off-delay
    bus_cycle(4'h9, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("motor_on_access", motor_on, 1);
    bus_cycle(4'h8, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("motor_off_access_hold", motor_on, 1);
    for (int i = 1; i <= 10; i++) begin
      idle_cycle();
      check($sformatf("motor_delay_fall%0d", i), motor_on, (i < 10) ? 1 : 0);
    end
    bus_cycle(4'h9, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    bus_cycle(4'h8, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (4) idle_cycle();
    bus_cycle(4'h9, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (10) idle_cycle();
    check("motor_cancel_off", motor_on, 1);
    bus_cycle(4'h8, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) idle_cycle();
    bus_cycle(4'h8, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (5) idle_cycle();
    check("motor_no_reload_fall9", motor_on, 1);
    idle_cycle();
    check("motor_no_reload_fall10", motor_on, 0);

    // read latch
    strobe(8'hD5);
    bus_cycle(4'hC, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("latch_read_d5", s_dout, 8'hD5);
    check("latch_read_oe", {s_oe_hi, s_oe_hi2, s_oe_lo}, 3'b110);
    bus_cycle(4'hC, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("latch_cleared", s_dout, 8'h00);
    strobe(8'hD5);
    bus_cycle(4'hC, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'hAA);
    check("latch_clear_cycle_read", s_dout, 8'hD5);
    bus_cycle(4'hC, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("latch_load_beats_clear", s_dout, 8'hAA);
    strobe(8'h45);
    bus_cycle(4'hC, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    bus_cycle(4'hC, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("latch_bit7_clear_kept", s_dout, 8'h45);

    // asynchronous reset in the middle of a read with the motor counting down
    bus_cycle(4'h9, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    bus_cycle(4'h8, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    bus_cycle(4'h3, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge fpga_clk);
    addr = 4'hC; rw = 1'b1; dev_sel_n = 1'b0;
    @(negedge fpga_clk);
    phi_2 = 1'b1; phi_0 = 1'b1;
    @(negedge fpga_clk);
    check("pre_reset_oe", data_oe, 1);
    check("pre_reset_motor", motor_on, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_oe", data_oe, 0);
    check("async_rst_motor", motor_on, 0);
    check("async_rst_phase", phase, 0);
    @(negedge fpga_clk);
    phi_2 = 1'b0; phi_0 = 1'b0; dev_sel_n = 1'b1;
    @(negedge fpga_clk);
    check("async_rst_no_strobe", wr_load, 0);
    reset = 1'b1;
    @(negedge fpga_clk);

    // random bus cycles against the model
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic [3:0] ra;
      logic       rr, rs, rwp;
      logic [7:0] rd;
      ra  = 4'($urandom_range(0, 15));
      rr  = 1'($urandom_range(0, 1));
      rd  = 8'($urandom);
      rs  = ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0;
      rwp = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 30) begin
        logic [7:0] sb;
        sb = 8'($urandom);
        strobe(sb);
        m_latch = sb;
      end
      model_cycle(ra, rr, rd, rs, rwp);
      bus_cycle(ra, rr, rd, rs, rwp, 1'b0, 8'h00);
      check($sformatf("rnd%0d_phase", n), phase, m_phase);
      check($sformatf("rnd%0d_motor", n), motor_on, m_motor);
      check($sformatf("rnd%0d_dsel_q6_q7", n), {drive_sel, q6, q7}, {m_dsel, m_q6, m_q7});
      check($sformatf("rnd%0d_oe", n), {s_oe_hi, s_oe_hi2, s_oe_lo}, {e_oe, e_oe, 1'b0});
      check($sformatf("rnd%0d_wr_pulses", n), s_wr, e_wr);
      if (e_oe) check($sformatf("rnd%0d_dout", n), s_dout, e_dout);
      if (e_wr != 0) check($sformatf("rnd%0d_wr_byte", n), s_wrb, m_wrb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
